// File: rtl/sample_stats_bcd_pkg.sv
// Shared definitions for the sample statistics / BCD display block:
// FSM encoding, display digit layout and the o_bcd packing helper.
package sample_stats_bcd_pkg;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_CONV_MAX,
    ST_CONV_P2P,
    ST_DONE
  } state_t;

  localparam logic [3:0] BLANK_DIGIT          = 4'hF;
  localparam int         BCD_DIGITS_PER_VALUE = 3;
  localparam int         BCD_VALUE_W          = 4 * BCD_DIGITS_PER_VALUE;

  localparam int MAX_LSB      = 20;
  localparam int BLANK_HI_LSB = 16;
  localparam int BLANK_LO_LSB = 12;
  localparam int P2P_LSB      = 0;

  function automatic logic [31:0] pack_bcd(input logic [BCD_VALUE_W-1:0] mx,
                                           input logic [BCD_VALUE_W-1:0] p2p);
    logic [31:0] r;
    r                         = '1;
    r[MAX_LSB +: BCD_VALUE_W] = mx;
    r[BLANK_HI_LSB +: 4]      = BLANK_DIGIT;
    r[BLANK_LO_LSB +: 4]      = BLANK_DIGIT;
    r[P2P_LSB +: BCD_VALUE_W] = p2p;
    return r;
  endfunction

endpackage

// File: rtl/sample_stats_bcd_bin2bcd_seq.sv
// Iterative double-dabble: one bit per cycle, the start edge already performs
// the first iteration, so o_done rises after exactly AD_DATA_WIDTH edges.
module bin2bcd_seq
  import sample_stats_bcd_pkg::*;
#(
  parameter int AD_DATA_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_start,
  input  logic [AD_DATA_WIDTH-1:0] i_bin,
  output logic                     o_done,
  output logic [BCD_VALUE_W-1:0]   o_bcd
);

  localparam int W  = AD_DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]          cnt;
  logic [W-1:0]           sh_r;
  logic [BCD_VALUE_W-1:0] bcd_r;
  logic [BCD_VALUE_W-1:0] adj;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < BCD_DIGITS_PER_VALUE; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= '0;
      sh_r  <= '0;
      bcd_r <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_start) begin
      // adjust of an all-zero BCD field is a no-op, so load and shift at once
      bcd_r <= {{(BCD_VALUE_W-1){1'b0}}, i_bin[W-1]};
      sh_r  <= {i_bin[W-2:0], 1'b0};
      cnt   <= CW'(1);
    end else if (cnt != '0 && cnt != CW'(W)) begin
      bcd_r <= {adj[BCD_VALUE_W-2:0], sh_r[W-1]};
      sh_r  <= {sh_r[W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
    end
  end

  assign o_done = (cnt == CW'(W));
  assign o_bcd  = bcd_r;

endmodule

// File: rtl/sample_stats_bcd.sv
// Windowed max / peak-to-peak of a dual-sample ADC stream, shown as BCD digits.
// One shared serial converter handles max first, then p2p.
module sample_stats_bcd
  import sample_stats_bcd_pkg::*;
#(
  parameter int AD_DATA_WIDTH = 8,
  parameter int WINDOW_LOG2   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [2*AD_DATA_WIDTH-1:0] i_dual_data,
  output logic                       o_ready,
  input  logic                       i_clear,
  output logic [31:0]                o_bcd,
  output logic                       o_bcd_valid
);

  localparam int W = AD_DATA_WIDTH;

  state_t                 state;
  logic [WINDOW_LOG2-1:0] cnt;
  logic [W-1:0]           run_max, run_min, shd_max, shd_min;
  logic [W-1:0]           lo, hi, smp_max, smp_min, new_max, new_min, p2p;
  logic [BCD_VALUE_W-1:0] max_bcd, conv_bcd;
  logic                   last, accept, conv_start, conv_done;
  logic [W-1:0]           conv_bin;

  assign lo      = i_dual_data[W-1:0];
  assign hi      = i_dual_data[2*W-1:W];
  assign smp_max = (lo > hi) ? lo : hi;
  assign smp_min = (lo < hi) ? lo : hi;
  assign new_max = (smp_max > run_max) ? smp_max : run_max;
  assign new_min = (smp_min < run_min) ? smp_min : run_min;
  assign p2p     = shd_max - shd_min;

  assign o_ready = (state == ST_ACC);
  assign last    = &cnt;
  assign accept  = i_valid && o_ready && !i_clear;

  // max conversion starts on the closing edge itself, from the combinational final max
  assign conv_start = (accept && last) ||
                      (state == ST_CONV_MAX && conv_done && !i_clear);
  assign conv_bin   = (state == ST_ACC) ? new_max : p2p;

  bin2bcd_seq #(.AD_DATA_WIDTH(W)) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_start (conv_start),
    .i_bin   (conv_bin),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_ACC;
      cnt         <= '0;
      run_max     <= '0;
      run_min     <= '1;
      shd_max     <= '0;
      shd_min     <= '0;
      max_bcd     <= '0;
      o_bcd       <= '1;
      o_bcd_valid <= 1'b0;
    end else begin
      o_bcd_valid <= 1'b0;
      if (i_clear) begin
        state   <= ST_ACC;
        cnt     <= '0;
        run_max <= '0;
        run_min <= '1;
      end else begin
        case (state)
          ST_ACC: if (accept) begin
            if (last) begin
              shd_max <= new_max;
              shd_min <= new_min;
              run_max <= '0;
              run_min <= '1;
              cnt     <= '0;
              state   <= ST_CONV_MAX;
            end else begin
              run_max <= new_max;
              run_min <= new_min;
              cnt     <= cnt + 1'b1;
            end
          end
          ST_CONV_MAX: if (conv_done) begin
            max_bcd <= conv_bcd;
            state   <= ST_CONV_P2P;
          end
          ST_CONV_P2P: if (conv_done) begin
            o_bcd       <= pack_bcd(max_bcd, conv_bcd);
            o_bcd_valid <= 1'b1;
            state       <= ST_DONE;
          end
          default: state <= ST_ACC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_stats_bcd.sv
// Directed bench for sample_stats_bcd with a 4-word window.
module tb_sample_stats_bcd;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_dual_data = '0;
  logic        o_ready;
  logic        i_clear = 1'b0;
  logic [31:0] o_bcd;
  logic        o_bcd_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_pulse = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;

  sample_stats_bcd #(.AD_DATA_WIDTH(8), .WINDOW_LOG2(2)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_dual_data (i_dual_data),
    .o_ready     (o_ready),
    .i_clear     (i_clear),
    .o_bcd       (o_bcd),
    .o_bcd_valid (o_bcd_valid)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (i_rst_n && i_valid && o_ready && !i_clear) last_acc = cyc;
    cyc = cyc + 1;
  end

  always @(negedge i_clk) begin
    if (o_bcd_valid) begin
      pulse_cnt  = pulse_cnt + 1;
      last_pulse = cyc;
    end
    if (!o_ready) busy_cnt = busy_cnt + 1;
  end

  task automatic send(input logic [15:0] d);
    int t = 0;
    @(negedge i_clk);
    while (!o_ready && t < 60) begin
      @(negedge i_clk);
      t++;
    end
    checks++;
    if (t >= 60) begin
      failures++;
      $display("FAIL send_ready_timeout: o_ready=%0b required 1", o_ready);
    end
    i_valid = 1'b1;
    i_dual_data = d;
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int base, input string name);
    int t = 0;
    while (pulse_cnt == base && t < 60) begin
      @(negedge i_clk);
      t++;
    end
    checks++;
    if (pulse_cnt == base) begin
      failures++;
      $display("FAIL %s_pulse_timeout: pulses=%0d required %0d", name, pulse_cnt, base + 1);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b required 1", o_ready); end
    checks++;
    if (o_bcd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_bcd: got %h required ffffffff", o_bcd); end
    checks++;
    if (o_bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b required 0", o_bcd_valid); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic();
    int base = pulse_cnt;
    int b0 = busy_cnt;
    send(16'h1005); send(16'h80FF); send(16'h4020); send(16'h3333);
    idle();
    wait_pulse(base, "basic");
    checks++;
    if (o_bcd !== 32'h255F_F250) begin failures++; $display("FAIL basic_bcd: got %h required 255ff250", o_bcd); end
    checks++;
    if (last_pulse - last_acc != 17) begin
      failures++; $display("FAIL basic_latency: got %0d required 17", last_pulse - last_acc);
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (busy_cnt - b0 != 17) begin failures++; $display("FAIL basic_busy: got %0d required 17", busy_cnt - b0); end
    checks++;
    if (pulse_cnt != base + 1) begin failures++; $display("FAIL basic_pulse_count: got %0d required %0d", pulse_cnt, base + 1); end
  endtask

  task automatic test_flat();
    int base = pulse_cnt;
    repeat (4) send(16'h7F7F);
    idle();
    wait_pulse(base, "flat");
    checks++;
    if (o_bcd !== 32'h127F_F000) begin failures++; $display("FAIL flat_bcd: got %h required 127ff000", o_bcd); end
  endtask

  task automatic test_back_to_back();
    int base = pulse_cnt;
    int b0 = busy_cnt;
    int p1;
    repeat (4) send(16'h0102);
    repeat (4) send(16'h0903);
    wait_pulse(base, "b2b_first");
    p1 = last_pulse;
    checks++;
    if (o_bcd !== 32'h002F_F001) begin failures++; $display("FAIL b2b_first_bcd: got %h required 002ff001", o_bcd); end
    idle();
    wait_pulse(base + 1, "b2b_second");
    checks++;
    if (o_bcd !== 32'h009F_F006) begin failures++; $display("FAIL b2b_second_bcd: got %h required 009ff006", o_bcd); end
    checks++;
    if (last_pulse - p1 != 21) begin failures++; $display("FAIL b2b_spacing: got %0d required 21", last_pulse - p1); end
    repeat (3) @(negedge i_clk);
    checks++;
    if (busy_cnt - b0 != 34) begin failures++; $display("FAIL b2b_busy: got %0d required 34", busy_cnt - b0); end
  endtask

  task automatic test_clear();
    int base = pulse_cnt;
    send(16'hFFFF); send(16'hFFFF);
    @(negedge i_clk);
    i_clear = 1'b1; i_valid = 1'b1; i_dual_data = 16'hFFFF;
    @(negedge i_clk);
    i_clear = 1'b0; i_valid = 1'b0;
    repeat (4) send(16'h0A0A);
    idle();
    wait_pulse(base, "clear");
    checks++;
    if (o_bcd !== 32'h010F_F000) begin failures++; $display("FAIL clear_bcd: got %h required 010ff000", o_bcd); end
    repeat (25) @(negedge i_clk);
    checks++;
    if (pulse_cnt != base + 1) begin failures++; $display("FAIL clear_pulse_count: got %0d required %0d", pulse_cnt, base + 1); end
  endtask

  task automatic test_clear_p2p();
    int base = pulse_cnt;
    repeat (4) send(16'h5050);
    idle();
    repeat (9) @(negedge i_clk);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    repeat (30) @(negedge i_clk);
    checks++;
    if (pulse_cnt != base) begin failures++; $display("FAIL clrp2p_no_pulse: got %0d required %0d", pulse_cnt, base); end
    checks++;
    if (o_bcd !== 32'h010F_F000) begin failures++; $display("FAIL clrp2p_hold: got %h required 010ff000", o_bcd); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL clrp2p_ready: got %0b required 1", o_ready); end
    repeat (4) send(16'h6432);
    idle();
    wait_pulse(base, "clrp2p_next");
    checks++;
    if (o_bcd !== 32'h100F_F050) begin failures++; $display("FAIL clrp2p_next_bcd: got %h required 100ff050", o_bcd); end
  endtask

  task automatic test_rst_conv();
    int base;
    repeat (4) send(16'h2211);
    idle();
    repeat (3) @(negedge i_clk);
    base = pulse_cnt;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_bcd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rstconv_bcd: got %h required ffffffff", o_bcd); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL rstconv_ready: got %0b required 1", o_ready); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (30) @(negedge i_clk);
    checks++;
    if (pulse_cnt != base) begin failures++; $display("FAIL rstconv_no_pulse: got %0d required %0d", pulse_cnt, base); end
    checks++;
    if (o_bcd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rstconv_hold: got %h required ffffffff", o_bcd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flat();
    test_back_to_back();
    test_clear();
    test_clear_p2p();
    test_rst_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_stats_bcd.md
SAMPLE_STATS_BCD -- requirements
Module: sample_stats_bcd

Interface
REQ-001 Parameter AD_DATA_WIDTH, default 8: width of one ADC sample.
REQ-002 Parameter WINDOW_LOG2, default 8: window length is 2^WINDOW_LOG2 accepted dual words.
REQ-003 i_clk  input  1: the single clock; all logic SHALL be on its rising edge.
REQ-004 i_rst_n  input  1: reset, asynchronous and active-low.
REQ-005 i_valid  input  1: i_dual_data is valid this cycle.
REQ-006 i_dual_data  input  2*AD_DATA_WIDTH: two packed unsigned samples; low half is the earlier sample.
REQ-007 o_ready  output  1: block accepts a word this cycle; a word is accepted when i_valid and o_ready are both 1.
REQ-008 i_clear  input  1: synchronous abort of the current window.
REQ-009 o_bcd  output  32: eight 4-bit display digits for the display driver.
REQ-010 o_bcd_valid  output  1: one-cycle pulse when o_bcd takes a new value.

Function
REQ-011 States SHALL be ACC, CONV_MAX, CONV_P2P and DONE; o_ready SHALL be 1 only in ACC.
REQ-012 In ACC, each accepted word SHALL update the running max and min over both samples and SHALL increment the word counter.
REQ-013 At window start, max SHALL be 0 and min SHALL be 2^AD_DATA_WIDTH-1.
REQ-014 The accepting edge of word 2^WINDOW_LOG2 (edge E0) SHALL latch the final max and min, including that word, into shadow registers, clear the running statistics and counter, and move the state to CONV_MAX.
REQ-015 Peak-to-peak SHALL equal shadow max minus shadow min, unsigned at AD_DATA_WIDTH bits; the result is never negative.
REQ-016 CONV_MAX SHALL run the iterative double-dabble on max for exactly AD_DATA_WIDTH cycles (edges E0 to E7); CONV_P2P SHALL do the same on p2p (edges E8 to E15); edge E16 enters DONE.
REQ-017 Edge E16 SHALL load o_bcd; o_bcd_valid SHALL be 1 for exactly the cycle after E16; edge E17 SHALL return the state to ACC.
REQ-018 o_ready SHALL be 0 for exactly 17 cycles per window; words presented with i_valid during that time SHALL NOT be accepted and SHALL NOT change any state.
REQ-019 o_bcd format: [31:20] max as 3 BCD digits, [19:16] 4'hF, [15:12] 4'hF, [11:0] p2p as 3 BCD digits; leading zeros are shown as 0.
REQ-020 i_clear SHALL have priority over i_valid; the word on that cycle is dropped.
REQ-021 i_clear in any state SHALL reset the counter, statistics and conversion and SHALL return the state to ACC on the next edge.
REQ-022 i_clear SHALL leave o_bcd unchanged and SHALL suppress any pending o_bcd_valid.
REQ-023 The counter SHALL wrap only through REQ-014 and SHALL never exceed 2^WINDOW_LOG2-1 in ACC.
REQ-024 o_bcd SHALL hold its last value until the next DONE.

Reset
REQ-025 While i_rst_n is 0, the state SHALL be ACC (o_ready=1).
REQ-026 While i_rst_n is 0: o_bcd=32'hFFFF_FFFF (all digits blank), o_bcd_valid=0, counter=0, max=0, min=all ones, shadows=0.
REQ-027 Reset asserted mid-conversion SHALL abort it with no o_bcd_valid pulse.

Structure
REQ-028 A shared package SHALL hold: state encoding, BLANK_DIGIT=4'hF, BCD_DIGITS_PER_VALUE=3, and the o_bcd field offsets.
REQ-029 One sub-module bin2bcd_seq SHALL perform the iterative AD_DATA_WIDTH-bit double-dabble, with a start/done handshake and a 12-bit BCD output.
REQ-030 bin2bcd_seq SHALL be instantiated once and reused for max, then p2p.

Verification (WINDOW_LOG2=2)
REQ-031 Words 16'h1005, 16'h80FF, 16'h4020, 16'h3333, each accepted -> o_bcd=32'h255F_F250, o_bcd_valid pulse exactly 17 cycles after the 4th accept.
REQ-032 Four words of 16'h7F7F -> o_bcd=32'h127F_F000.
REQ-033 i_valid held high through a full window -> exactly 17 cycles of o_ready=0, then the next window counts from 0 (second pulse 21 cycles after the first).
REQ-034 Two words, then i_clear with i_valid=1, then four words of 16'h0A0A -> single pulse, o_bcd=32'h010F_F000.
REQ-035 i_clear during CONV_P2P -> no pulse; o_bcd keeps its prior value; the next full window converts normally.
REQ-036 i_rst_n=0 during CONV_MAX -> o_bcd=32'hFFFF_FFFF, o_ready=1, no pulse.
